maze_path_checker: RTL and testbench

- Consumer end of the maze solver's result stream.
- Loads the same 17x17 serial maze bitstream the solver receives, then accepts the solver's direction stream (valid + 2-bit direction).
- Walks the path from (0,0), reports pass/fail, an error code and the step count.
- Sits beside the solver in the block-level testbench and in the on-chip self-check wrapper.

---
 rtl/maze_path_checker.sv | 203 ++++++++++++++++++++
 tb/tb_maze_path_checker.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maze_path_checker.sv
// rtl/maze_path_checker.sv - walks a solver direction stream over a loaded maze and reports a verdict
module maze_path_checker #(
  parameter int MAZE_WIDTH = 17,
  parameter int MAX_STEPS  = 150,
  parameter int TIMEOUT    = 4095,
  parameter int STEP_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in,
  input  logic              path_valid,
  input  logic [1:0]        path_dir,
  output logic              done,
  output logic              pass,
  output logic [2:0]        err_code,
  output logic [STEP_W-1:0] step_count
);

  localparam int CELLS = MAZE_WIDTH * MAZE_WIDTH;
  localparam int IDX_W = $clog2(CELLS);
  localparam int XY_W  = $clog2(MAZE_WIDTH);
  localparam int SXY_W = XY_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  localparam logic signed [SXY_W-1:0] S_LAST = SXY_W'(MAZE_WIDTH - 1);
  localparam logic [XY_W-1:0]         U_LAST = XY_W'(MAZE_WIDTH - 1);

  localparam logic [2:0] ERR_OK         = 3'd0;
  localparam logic [2:0] ERR_WALL       = 3'd1;
  localparam logic [2:0] ERR_OOB        = 3'd2;
  localparam logic [2:0] ERR_NOT_AT_GOAL = 3'd3;
  localparam logic [2:0] ERR_TOO_LONG   = 3'd4;
  localparam logic [2:0] ERR_TIMEOUT    = 3'd5;
  localparam logic [2:0] ERR_SHORT_MAZE = 3'd6;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_PATH,
    WALK,
    REPORT
  } state_t;

  state_t state, state_next;

  logic [CELLS-1:0]        maze;
  logic [IDX_W-1:0]        bit_cnt;
  logic [TMO_W-1:0]        tmo_cnt;
  logic [XY_W-1:0]         pos_x, pos_y;

  logic signed [SXY_W-1:0] dx, dy, nx, ny;
  logic                    oob;
  logic [IDX_W-1:0]        next_idx;
  logic                    next_open;
  logic                    at_goal;
  logic                    beat;
  logic [2:0]              beat_err;
  logic [2:0]              err_new;
  logic [2:0]              err_final;

  // Evaluate where the current direction beat would take us and what it would violate
  always_comb begin
    dx = '0;
    dy = '0;
    case (path_dir)
      2'd0: dy = SXY_W'(1);
      2'd1: dx = SXY_W'(1);
      2'd2: dy = '1;
      2'd3: dx = '1;
    endcase
    nx        = $signed({1'b0, pos_x}) + dx;
    ny        = $signed({1'b0, pos_y}) + dy;
    oob       = nx[SXY_W-1] | ny[SXY_W-1] | (nx > S_LAST) | (ny > S_LAST);
    next_idx  = IDX_W'(nx[XY_W-1:0]) * IDX_W'(MAZE_WIDTH) + IDX_W'(ny[XY_W-1:0]);
    next_open = maze[next_idx];
    at_goal   = (pos_x == U_LAST) && (pos_y == U_LAST);
    beat      = path_valid && ((state == WAIT_PATH) || (state == WALK));
    beat_err  = ERR_OK;
    if (oob) begin
      beat_err = ERR_OOB;
    end else if (!next_open) begin
      beat_err = ERR_WALL;
    end else if (step_count == STEP_W'(MAX_STEPS)) begin
      beat_err = ERR_TOO_LONG;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decision and the error this cycle would raise
  always_comb begin
    state_next = state;
    err_new    = ERR_OK;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (!in_valid) begin
          err_new    = ERR_SHORT_MAZE;
          state_next = REPORT;
        end else if (bit_cnt == IDX_W'(CELLS - 1)) begin
          state_next = WAIT_PATH;
        end
      end
      WAIT_PATH: begin
        if (path_valid) begin
          err_new    = beat_err;
          state_next = WALK;
        end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
          err_new    = ERR_TIMEOUT;
          state_next = REPORT;
        end
      end
      WALK: begin
        if (path_valid) begin
          err_new = beat_err;
        end else begin
          if (!at_goal) begin
            err_new = ERR_NOT_AT_GOAL;
          end
          state_next = REPORT;
        end
      end
      REPORT: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    err_final = (err_code != ERR_OK) ? err_code : err_new;
  end

  // Maze storage, counters, position and the sticky verdict registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      maze       <= '0;
      bit_cnt    <= '0;
      tmo_cnt    <= '0;
      pos_x      <= '0;
      pos_y      <= '0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_code   <= ERR_OK;
      step_count <= '0;
    end else begin
      done <= (state_next == REPORT);
      if (state_next == REPORT) begin
        pass <= (err_final == ERR_OK);
      end
      if (err_code == ERR_OK) begin
        err_code <= err_new;
      end
      case (state)
        IDLE: begin
          if (in_valid) begin
            maze[0]    <= in;
            bit_cnt    <= IDX_W'(1);
            pos_x      <= '0;
            pos_y      <= '0;
            pass       <= 1'b0;
            err_code   <= ERR_OK;
            step_count <= '0;
          end
        end
        LOAD: begin
          tmo_cnt <= '0;
          if (in_valid) begin
            maze[bit_cnt] <= in;
            bit_cnt       <= bit_cnt + IDX_W'(1);
          end
        end
        WAIT_PATH, WALK: begin
          if (beat) begin
            if (step_count != '1) begin
              step_count <= step_count + STEP_W'(1);
            end
            if ((err_code == ERR_OK) && (beat_err == ERR_OK)) begin
              pos_x <= nx[XY_W-1:0];
              pos_y <= ny[XY_W-1:0];
            end
          end else if (state == WAIT_PATH) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_maze_path_checker.sv
// tb/tb_maze_path_checker.sv - table, hand-written and randomized checks of maze_path_checker
module tb_maze_path_checker;

  localparam int W     = 17;
  localparam int CELLS = W * W;
  localparam int TMO   = 4095;
  localparam int MAXS  = 150;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;
  logic       path_valid = 1'b0;
  logic [1:0] path_dir = 2'd0;
  logic       done;
  logic       pass;
  logic [2:0] err_code;
  logic [7:0] step_count;

  maze_path_checker dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in         (in_bit),
    .path_valid (path_valid),
    .path_dir   (path_dir),
    .done       (done),
    .pass       (pass),
    .err_code   (err_code),
    .step_count (step_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int done_total = 0;
  int done_edge = 0;
  int cap_pass = 0;
  int cap_err = 0;
  int cap_steps = 0;

  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_total = done_total + 1;
      done_edge  = cyc;
      cap_pass   = int'(pass);
      cap_err    = int'(err_code);
      cap_steps  = int'(step_count);
    end
  end

  int tests = 0;
  int fails = 0;
  int dq[$];
  int exp_done_edge = 0;

  typedef struct {
    string name;
    int    wall;
    int    nbits;
    int    gap;
    int    pat;
    int    n_alt;
    int    exp_err;
    int    exp_pass;
    int    exp_steps;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input int act, input int exp);
    tests = tests + 1;
    if (act != exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic build_dirs(input int pat, input int n);
    dq.delete();
    case (pat)
      1: begin
        for (int i = 0; i < 16; i++) dq.push_back(0);
        for (int i = 0; i < 16; i++) dq.push_back(1);
      end
      2: begin dq.push_back(0); dq.push_back(1); end
      3: begin dq.push_back(3); dq.push_back(0); end
      4: for (int i = 0; i < 16; i++) dq.push_back(0);
      5: for (int i = 0; i < n; i++) dq.push_back((i % 2 == 0) ? 0 : 2);
      6: begin
        for (int i = 0; i < n; i++) dq.push_back((i % 2 == 0) ? 0 : 2);
        for (int i = 0; i < 16; i++) dq.push_back(0);
        for (int i = 0; i < 16; i++) dq.push_back(1);
      end
      default: begin end
    endcase
  endtask

  // Reference: plain grid walk following the verdict rules
  function automatic void model(input logic [CELLS-1:0] m, input int nbits, input int gap,
                                output int e, output int p, output int s);
    int x;
    int y;
    int nx;
    int ny;
    x = 0; y = 0; e = 0; s = 0;
    if (nbits < CELLS) begin
      e = 6;
    end else if (gap >= TMO) begin
      e = 5;
    end else begin
      foreach (dq[i]) begin
        nx = x; ny = y;
        case (dq[i])
          0: ny = ny + 1;
          1: nx = nx + 1;
          2: ny = ny - 1;
          default: nx = nx - 1;
        endcase
        if (e == 0) begin
          if (nx < 0 || nx >= W || ny < 0 || ny >= W) e = 2;
          else if (m[nx * W + ny] == 1'b0) e = 1;
          else if (s == MAXS) e = 4;
          else begin x = nx; y = ny; end
        end
        if (s < 255) s = s + 1;
      end
      if (e == 0 && !(x == W - 1 && y == W - 1)) e = 3;
    end
    p = (e == 0) ? 1 : 0;
  endfunction

  task automatic drive_run(input logic [CELLS-1:0] m, input int nbits, input int gap,
                           input bit noise, output int n_done);
    int base;
    int last_bit_edge;
    int last_beat_edge;
    base = done_total;
    last_bit_edge = 0;
    last_beat_edge = 0;
    for (int k = 0; k < nbits; k++) begin
      @(negedge clk);
      in_valid   = 1'b1;
      in_bit     = m[k];
      path_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      path_dir   = 2'($urandom_range(0, 3));
      last_bit_edge = cyc + 1;
    end
    if (nbits < CELLS) begin
      @(negedge clk);
      in_valid = 1'b0; in_bit = 1'b0; path_valid = 1'b0;
      exp_done_edge = cyc + 1;
    end else begin
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        in_valid = 1'b0; in_bit = 1'b0; path_valid = 1'b0;
      end
      foreach (dq[i]) begin
        @(negedge clk);
        in_valid   = (noise && i > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        in_bit     = 1'($urandom_range(0, 1));
        path_valid = 1'b1;
        path_dir   = 2'(dq[i]);
        last_beat_edge = cyc + 1;
      end
      @(negedge clk);
      in_valid = 1'b0; in_bit = 1'b0; path_valid = 1'b0;
      exp_done_edge = (dq.size() == 0 || gap >= TMO) ? last_bit_edge + TMO : last_beat_edge + 1;
    end
    for (int w = 0; w < TMO + 50 && (done_total - base) == 0; w++) @(negedge clk);
    repeat (3) @(negedge clk);
    n_done = done_total - base;
  endtask

  initial begin
    logic [CELLS-1:0] m;
    int nd;
    int e;
    int p;
    int s;

    vecs[0]  = '{"open_path",    -1, 289, 0,    1, 0,   0, 1, 32};
    vecs[1]  = '{"wall",          1, 289, 0,    2, 0,   1, 0, 2};
    vecs[2]  = '{"oob_sticky",    1, 289, 2,    3, 0,   2, 0, 2};
    vecs[3]  = '{"not_goal",     -1, 289, 0,    4, 0,   3, 0, 16};
    vecs[4]  = '{"too_long",     -1, 289, 0,    5, 151, 4, 0, 151};
    vecs[5]  = '{"exact_max",    -1, 289, 1,    6, 118, 0, 1, 150};
    vecs[6]  = '{"max_plus",     -1, 289, 0,    6, 120, 4, 0, 152};
    vecs[7]  = '{"max_not_goal", -1, 289, 0,    5, 150, 3, 0, 150};
    vecs[8]  = '{"late_start",   -1, 289, 4094, 1, 0,   0, 1, 32};
    vecs[9]  = '{"timeout",      -1, 289, 4095, 0, 0,   5, 0, 0};
    vecs[10] = '{"short",        -1, 100, 0,    0, 0,   6, 0, 0};

    repeat (2) @(negedge clk);
    check("reset_done", int'(done), 0);
    check("reset_pass", int'(pass), 0);
    check("reset_err", int'(err_code), 0);
    check("reset_steps", int'(step_count), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 11; v++) begin
      m = '1;
      if (vecs[v].wall >= 0) m[vecs[v].wall] = 1'b0;
      build_dirs(vecs[v].pat, vecs[v].n_alt);
      drive_run(m, vecs[v].nbits, vecs[v].gap, 1'b0, nd);
      check({vecs[v].name, "_done_count"}, nd, 1);
      check({vecs[v].name, "_done_cycle"}, done_edge, exp_done_edge);
      check({vecs[v].name, "_err"}, cap_err, vecs[v].exp_err);
      check({vecs[v].name, "_pass"}, cap_pass, vecs[v].exp_pass);
      check({vecs[v].name, "_steps"}, cap_steps, vecs[v].exp_steps);
      check({vecs[v].name, "_hold_err"}, int'(err_code), vecs[v].exp_err);
      check({vecs[v].name, "_hold_steps"}, int'(step_count), vecs[v].exp_steps);
    end

    // A passing run, then a single maze bit must clear the held verdict at once
    m = '1;
    build_dirs(1, 0);
    drive_run(m, CELLS, 0, 1'b0, nd);
    check("pre_clear_pass", int'(pass), 1);
    @(negedge clk);
    in_valid = 1'b1; in_bit = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_bit = 1'b0;
    check("clear_pass", int'(pass), 0);
    check("clear_err", int'(err_code), 0);
    check("clear_steps", int'(step_count), 0);
    @(negedge clk);
    check("one_bit_short_done", int'(done), 1);
    check("one_bit_short_err", int'(err_code), 6);
    repeat (2) @(negedge clk);

    // Asynchronous reset wipes a held error without a clock edge
    m = '1;
    m[1] = 1'b0;
    build_dirs(2, 0);
    drive_run(m, CELLS, 0, 1'b0, nd);
    check("pre_reset_err", int'(err_code), 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_err", int'(err_code), 0);
    check("async_reset_steps", int'(step_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    m = '1;
    build_dirs(1, 0);
    drive_run(m, CELLS, 0, 1'b0, nd);
    check("after_reset_pass", cap_pass, 1);

    // Randomized mazes and paths against the reference walk
    for (int r = 0; r < 14; r++) begin
      int len;
      int gap;
      for (int k = 0; k < CELLS; k++) m[k] = ($urandom_range(0, 99) < 85) ? 1'b1 : 1'b0;
      dq.delete();
      if (r % 2 == 0) begin
        for (int y = 0; y < W; y++) m[y] = 1'b1;
        for (int x = 0; x < W; x++) m[x * W + W - 1] = 1'b1;
        build_dirs(1, 0);
        len = $urandom_range(0, 3);
        for (int i = 0; i < len; i++) dq.push_back($urandom_range(0, 3));
      end else begin
        len = (r % 5 == 1) ? $urandom_range(140, 170) : $urandom_range(1, 60);
        for (int i = 0; i < len; i++) begin
          int t;
          t = $urandom_range(0, 9);
          dq.push_back((t < 4) ? 0 : (t < 8) ? 1 : (t == 8) ? 2 : 3);
        end
      end
      gap = $urandom_range(0, 3);
      model(m, CELLS, gap, e, p, s);
      drive_run(m, CELLS, gap, 1'($urandom_range(0, 1)), nd);
      check($sformatf("rand%0d_done_count", r), nd, 1);
      check($sformatf("rand%0d_err", r), cap_err, e);
      check($sformatf("rand%0d_pass", r), cap_pass, p);
      check($sformatf("rand%0d_steps", r), cap_steps, s);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
